// File: rtl/bus_pkg.sv
// Shared widths and FSM state encoding for the serial slave port.
// Defining SLAVE_PORT_PARITY_EN adds the PARITY state for the optional frame parity check.
package bus_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        SP_IDLE   = 2'd0,
        SP_SHIFT  = 2'd1,
`ifdef SLAVE_PORT_PARITY_EN
        SP_PARITY = 2'd2,
`endif
        SP_HOLD   = 2'd3
    } sp_state_e;

    // Bit-counter width; a one-bit address still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_deser.sv
// Serial-to-parallel converter: writes one address/data bit per enabled cycle at a given index
// and copies the assembled frame into the output registers on load. Parity output needs SLAVE_PORT_PARITY_EN.
module serial_deser
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_W      = cnt_width(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en_i,
    input  logic [CNT_W-1:0]      bit_idx_i,
    input  logic                  addr_bit_i,
    input  logic                  data_bit_i,
    input  logic                  load_i,
`ifdef SLAVE_PORT_PARITY_EN
    output logic                  parity_o,
`endif
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [ADDR_WIDTH-1:0] shift_addr_q, shift_addr_d;
    logic [DATA_WIDTH-1:0] shift_data_q, shift_data_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Data bits only exist for indices below DATA_WIDTH; later indices touch the address only.
    always_comb begin
        shift_addr_d = shift_addr_q;
        shift_data_d = shift_data_q;
        if (shift_en_i) begin
            for (int i = 0; i < ADDR_WIDTH; i++) begin
                if (bit_idx_i == CNT_W'(i)) shift_addr_d[i] = addr_bit_i;
            end
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (bit_idx_i == CNT_W'(i)) shift_data_d[i] = data_bit_i;
            end
        end
    end

    // NOTE: the shift register has no reset; every bit is rewritten by a complete frame
    // before a load can ever expose it.
    always_ff @(posedge clk) begin
        shift_addr_q <= shift_addr_d;
        shift_data_q <= shift_data_d;
    end

    // Load takes the _d view so the bit captured on the final shift cycle is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (load_i) begin
            addr_q <= shift_addr_d;
            data_q <= shift_data_d;
        end
    end

`ifdef SLAVE_PORT_PARITY_EN
    assign parity_o = ^{shift_addr_q, shift_data_q};
`endif

    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/slave_port.sv
// Serial bus slave port: deserialises an LSB-first address/write-data frame and presents it as a
// valid/ready write request. SLAVE_PORT_PARITY_EN adds a trailing even-parity cycle to each frame.
module slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sp_valid,
    input  logic                  sp_addr,
    input  logic                  sp_wdata,
    output logic                  sp_ready,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    output logic                  s_valid,
    input  logic                  s_ready,
    output logic                  s_err
);

    localparam int              CNT_W    = cnt_width(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ADDR_WIDTH - 1);

    sp_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sp_ready_q;
    logic             s_valid_q;
    logic             s_err_q, s_err_d;
    logic             shift_en;
    logic             load;
`ifdef SLAVE_PORT_PARITY_EN
    logic             frame_parity;
`endif

    serial_deser #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_deser (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (shift_en),
        .bit_idx_i  (cnt_q),
        .addr_bit_i (sp_addr),
        .data_bit_i (sp_wdata),
        .load_i     (load),
`ifdef SLAVE_PORT_PARITY_EN
        .parity_o   (frame_parity),
`endif
        .addr_o     (s_addr),
        .data_o     (s_wdata)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        s_err_d  = 1'b0;
        shift_en = 1'b0;
        load     = 1'b0;
        case (state_q)
            // IDLE and SHIFT capture identically; the counter is 0 in IDLE so bit 0 lands first.
            SP_IDLE, SP_SHIFT: begin
                if (sp_valid) begin
                    shift_en = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
`ifdef SLAVE_PORT_PARITY_EN
                        state_d = SP_PARITY;
`else
                        state_d = SP_HOLD;
                        load    = 1'b1;
`endif
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = SP_SHIFT;
                    end
                end else if (state_q == SP_SHIFT) begin
                    cnt_d   = '0;
                    s_err_d = 1'b1;
                    state_d = SP_IDLE;
                end
            end
`ifdef SLAVE_PORT_PARITY_EN
            SP_PARITY: begin
                if (sp_valid && (sp_wdata == frame_parity)) begin
                    state_d = SP_HOLD;
                    load    = 1'b1;
                end else begin
                    s_err_d = 1'b1;
                    state_d = SP_IDLE;
                end
            end
`endif
            SP_HOLD: begin
                if (s_valid_q && s_ready) state_d = SP_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = SP_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SP_IDLE;
            cnt_q      <= '0;
            sp_ready_q <= 1'b1;
            s_valid_q  <= 1'b0;
            s_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sp_ready_q <= (state_d == SP_IDLE);
            s_valid_q  <= (state_d == SP_HOLD);
            s_err_q    <= s_err_d;
        end
    end

    assign sp_ready = sp_ready_q;
    assign s_valid  = s_valid_q;
    assign s_err    = s_err_q;

endmodule

// File: doc/slave_port.md
SLAVE_PORT -- requirements
Module: slave_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, serial address length in bits.
REQ-002 Parameter DATA_WIDTH, default 8, serial write-data length in bits; SHALL be <= ADDR_WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sp_valid  input  1  bus frame strobe, high for every bit cycle of a frame.
REQ-006 sp_addr  input  1  serial address bit, LSB first.
REQ-007 sp_wdata  input  1  serial write-data bit, LSB first, parallel with the first DATA_WIDTH address bits.
REQ-008 sp_ready  output  1  port idle and able to accept a new frame.
REQ-009 s_addr  output  ADDR_WIDTH  deserialised address to slave.
REQ-010 s_wdata  output  DATA_WIDTH  deserialised write data to slave.
REQ-011 s_valid  output  1  write request to slave.
REQ-012 s_ready  input  1  slave accepts request.
REQ-013 s_err  output  1  one-cycle pulse on aborted or corrupted frame.

Function
REQ-014 States SHALL be IDLE, SHIFT, PARITY (macro only) and HOLD; bit counter width $clog2(ADDR_WIDTH).
REQ-015 sp_ready SHALL be 1 only in IDLE, registered.
REQ-016 IDLE with sp_valid=1: capture bit 0 of sp_addr/sp_wdata, counter=1, go SHIFT.
REQ-017 SHIFT with sp_valid=1: capture addr bit [counter], data bit [counter] only while counter<DATA_WIDTH; increment counter.
REQ-018 After address bit ADDR_WIDTH-1 is captured: go HOLD, or go PARITY when the macro is defined.
REQ-019 SHIFT with sp_valid=0 (mid-frame drop): discard frame, pulse s_err for one cycle, return to IDLE; s_valid stays 0.
REQ-020 HOLD: s_valid=1, s_addr/s_wdata stable; on s_valid&&s_ready go IDLE; sp_ready is 1 on the following cycle.
REQ-021 Latency: s_valid SHALL rise on the cycle after the last address bit (one cycle later with parity).
REQ-022 sp_valid in HOLD SHALL be ignored; no bits captured, no error.
REQ-023 s_addr/s_wdata SHALL hold the last completed frame outside HOLD; the shift register is separate from the output registers, which load on entry to HOLD.
REQ-024 s_ready high while s_valid=0 SHALL have no effect.

Reset
REQ-025 rst asserted: state IDLE, counter 0, s_addr=0, s_wdata=0, s_valid=0, s_err=0, sp_ready=1 immediately, without waiting for a clock edge.
REQ-026 Reset mid-frame or in HOLD SHALL discard the frame with no s_valid and no s_err.

Configuration
REQ-027 Macro SLAVE_PORT_PARITY_EN defined: frame carries one extra cycle (sp_valid=1) whose sp_wdata is even parity over all ADDR_WIDTH+DATA_WIDTH bits. On match go HOLD; on mismatch pulse s_err, go IDLE. sp_valid=0 in PARITY is treated as REQ-019.
REQ-028 Macro undefined: no PARITY state, no parity logic; s_err driven only by REQ-019.

Structure
REQ-029 Shared package bus_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH defaults and the slave_port state enum.
REQ-030 Serial-to-parallel shifting SHALL live in sub-module serial_deser (shift enable, bit index, load); FSM, counter and handshake stay in slave_port.

Verification
REQ-031 Frame addr 16'h1234, data 8'hA5, 16 cycles sp_valid, s_ready=1 -> s_valid one cycle after last bit with s_addr=16'h1234, s_wdata=8'hA5; sp_ready back 1 the next cycle.
REQ-032 Same frame, s_ready held 0 for 5 cycles -> s_valid and outputs stable for 5 cycles, IDLE after handshake; sp_valid pulses in HOLD ignored.
REQ-033 sp_valid dropped after 7 bits of addr 16'hFFFF -> s_err one cycle, no s_valid, sp_ready=1 next cycle; following frame 16'h0001/8'h01 received correctly.
REQ-034 rst asserted asynchronously at bit 10 of a frame -> all outputs at reset values before next edge; no s_valid, no s_err.
REQ-035 SLAVE_PORT_PARITY_EN: frame 16'h1234/8'hA5 with correct parity bit 1 -> accepted; parity bit inverted -> s_err pulse, no s_valid.
REQ-036 Back-to-back frames 16'hBEEF/8'h3C then 16'h0F0F/8'hC3, second started the cycle sp_ready rises -> both delivered in order, values exact.
